whistle_event_detector: RTL and testbench

Multi-band, debounced whistle event qualifier that sits between the FFT pitch detector and the fire/display logic. It replaces the single-threshold whistle flag with one frame-driven state machine per band. Each band has a programmable bin window, on/off threshold hysteresis, consecutive-frame debounce and a post-release holdoff. It produces per-band activity levels, a fire output (pulse or level mode) and a saturating event counter.

---
 rtl/whistle_event_detector.sv | 157 +++++++++++++++
 tb/tb_whistle_event_detector.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/whistle_event_detector.sv
// Multi-band whistle event qualifier: one frame-driven FSM per band with bin window,
// on/off threshold hysteresis, hit/miss debounce and post-release holdoff.
module whistle_event_detector #(
  parameter int PITCH_W        = 10,
  parameter int MAG_W          = 33,
  parameter int NUM_BANDS      = 4,
  parameter int ON_FRAMES      = 3,
  parameter int OFF_FRAMES     = 2,
  parameter int HOLDOFF_FRAMES = 8,
  parameter int CNT_W          = 8,
  localparam int BW            = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [PITCH_W-1:0]            pitch_data,
  input  logic [MAG_W-1:0]              pitch_mag,
  input  logic                          pitch_valid,
  input  logic [NUM_BANDS*PITCH_W-1:0]  band_lo,
  input  logic [NUM_BANDS*PITCH_W-1:0]  band_hi,
  input  logic [MAG_W-1:0]              thresh_on,
  input  logic [MAG_W-1:0]              thresh_off,
  input  logic                          pulse_mode,
  input  logic                          clear_count,
  output logic [NUM_BANDS-1:0]          active,
  output logic                          fire,
  output logic [BW-1:0]                 fire_band,
  output logic [CNT_W-1:0]              event_count,
  output logic [NUM_BANDS*3-1:0]        band_state
);

  // pitch_valid is a one-cycle frame qualifier with no backpressure: every cycle it is
  // high is consumed as exactly one frame, back-to-back frames included.

  localparam int CMAX0 = (ON_FRAMES > OFF_FRAMES) ? ON_FRAMES : OFF_FRAMES;
  localparam int CMAX  = (CMAX0 > HOLDOFF_FRAMES) ? CMAX0 : HOLDOFF_FRAMES;
  localparam int CW    = $clog2(CMAX + 1);
  localparam logic [CW-1:0] ON_C   = CW'(ON_FRAMES);
  localparam logic [CW-1:0] OFF_C  = CW'(OFF_FRAMES);
  localparam logic [CW-1:0] HOLD_C = CW'(HOLDOFF_FRAMES);

  typedef enum logic [2:0] {
    S_IDLE, S_ARMING, S_ACTIVE, S_RELEASING, S_HOLDOFF
  } state_t;

  state_t          state_q [NUM_BANDS];
  state_t          state_d [NUM_BANDS];
  logic [CW-1:0]   cnt_q   [NUM_BANDS];
  logic [CW-1:0]   cnt_d   [NUM_BANDS];
  logic [NUM_BANDS-1:0] hit, enter, act_d;
  logic [BW-1:0]   enter_idx, active_idx;
  logic            any_event;

  for (genvar g = 0; g < NUM_BANDS; g++) begin : g_band
    logic [PITCH_W-1:0] lo, hi;
    logic [MAG_W-1:0]   thr;
    assign lo  = band_lo[g*PITCH_W +: PITCH_W];
    assign hi  = band_hi[g*PITCH_W +: PITCH_W];
    // Once a band is holding, the lower thresh_off keeps it alive (hysteresis).
    assign thr = (state_q[g] == S_ACTIVE || state_q[g] == S_RELEASING) ? thresh_off : thresh_on;
    assign hit[g] = (pitch_data >= lo) && (pitch_data <= hi) && (pitch_mag >= thr);
    assign band_state[g*3 +: 3] = state_q[g];
  end

  always_comb begin
    for (int b = 0; b < NUM_BANDS; b++) begin
      state_d[b] = state_q[b];
      cnt_d[b]   = cnt_q[b];
      enter[b]   = 1'b0;
      if (pitch_valid) begin
        case (state_q[b])
          S_IDLE: if (hit[b]) begin
            if (ON_FRAMES == 1) begin
              state_d[b] = S_ACTIVE; cnt_d[b] = '0; enter[b] = 1'b1;
            end else begin
              state_d[b] = S_ARMING; cnt_d[b] = CW'(1);
            end
          end
          S_ARMING: if (hit[b]) begin
            if (cnt_q[b] + 1'b1 == ON_C) begin
              state_d[b] = S_ACTIVE; cnt_d[b] = '0; enter[b] = 1'b1;
            end else begin
              cnt_d[b] = cnt_q[b] + 1'b1;
            end
          end else begin
            state_d[b] = S_IDLE; cnt_d[b] = '0;
          end
          S_ACTIVE: if (!hit[b]) begin
            if (OFF_FRAMES == 1) begin
              state_d[b] = (HOLDOFF_FRAMES == 0) ? S_IDLE : S_HOLDOFF; cnt_d[b] = '0;
            end else begin
              state_d[b] = S_RELEASING; cnt_d[b] = CW'(1);
            end
          end
          S_RELEASING: if (hit[b]) begin
            state_d[b] = S_ACTIVE; cnt_d[b] = '0;
          end else if (cnt_q[b] + 1'b1 == OFF_C) begin
            state_d[b] = (HOLDOFF_FRAMES == 0) ? S_IDLE : S_HOLDOFF; cnt_d[b] = '0;
          end else begin
            cnt_d[b] = cnt_q[b] + 1'b1;
          end
          S_HOLDOFF: if (cnt_q[b] + 1'b1 == HOLD_C) begin
            state_d[b] = S_IDLE; cnt_d[b] = '0;
          end else begin
            cnt_d[b] = cnt_q[b] + 1'b1;
          end
          default: begin
            state_d[b] = S_IDLE; cnt_d[b] = '0;
          end
        endcase
      end
      act_d[b] = (state_d[b] == S_ACTIVE) || (state_d[b] == S_RELEASING);
    end
  end

  // Walk downward so the lowest qualifying index is the one left standing.
  always_comb begin
    enter_idx  = '0;
    active_idx = '0;
    for (int b = NUM_BANDS - 1; b >= 0; b--) begin
      if (enter[b]) enter_idx  = BW'(b);
      if (act_d[b]) active_idx = BW'(b);
    end
  end

  assign any_event = |enter;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int b = 0; b < NUM_BANDS; b++) begin
        state_q[b] <= S_IDLE;
        cnt_q[b]   <= '0;
      end
      active      <= '0;
      fire        <= 1'b0;
      fire_band   <= '0;
      event_count <= '0;
    end else begin
      for (int b = 0; b < NUM_BANDS; b++) begin
        state_q[b] <= state_d[b];
        cnt_q[b]   <= cnt_d[b];
      end
      active <= act_d;
      if (pulse_mode) begin
        fire <= any_event;
        if (any_event) fire_band <= enter_idx;
      end else begin
        fire      <= |act_d;
        fire_band <= active_idx;
      end
      if (clear_count)
        event_count <= '0;
      else if (any_event && event_count != '1)
        event_count <= event_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_whistle_event_detector.sv
// Bench for whistle_event_detector: directed frames, a frame-level behavioural model
// compared every cycle, and literal checks at the key points of each scenario.
module tb_whistle_event_detector;

  localparam int NB = 4;
  localparam int PW = 10;
  localparam int MW = 33;
  localparam int ON = 3;
  localparam int OFF = 2;
  localparam int HOLD = 8;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [PW-1:0]   pitch_data;
  logic [MW-1:0]   pitch_mag;
  logic            pitch_valid;
  logic [NB*PW-1:0] band_lo, band_hi;
  logic [MW-1:0]   thresh_on, thresh_off;
  logic            pulse_mode, clear_count;
  logic [NB-1:0]   active, active_s;
  logic            fire, fire_s;
  logic [1:0]      fire_band, fire_band_s;
  logic [7:0]      event_count;
  logic [1:0]      event_count_s;
  logic [NB*3-1:0] band_state, band_state_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  whistle_event_detector dut (
    .clk(clk), .reset_n(reset_n), .pitch_data(pitch_data), .pitch_mag(pitch_mag),
    .pitch_valid(pitch_valid), .band_lo(band_lo), .band_hi(band_hi),
    .thresh_on(thresh_on), .thresh_off(thresh_off), .pulse_mode(pulse_mode),
    .clear_count(clear_count), .active(active), .fire(fire), .fire_band(fire_band),
    .event_count(event_count), .band_state(band_state));

  whistle_event_detector #(.CNT_W(2)) dut_sat (
    .clk(clk), .reset_n(reset_n), .pitch_data(pitch_data), .pitch_mag(pitch_mag),
    .pitch_valid(pitch_valid), .band_lo(band_lo), .band_hi(band_hi),
    .thresh_on(thresh_on), .thresh_off(thresh_off), .pulse_mode(pulse_mode),
    .clear_count(clear_count), .active(active_s), .fire(fire_s), .fire_band(fire_band_s),
    .event_count(event_count_s), .band_state(band_state_s));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: runs of hits arm a band, runs of misses release it,
  // a release starts a countdown during which the band ignores input.
  int  m_run [NB];
  int  m_miss[NB];
  int  m_hold[NB];
  bit  m_act [NB];
  bit  exp_fire;
  int  exp_fb;
  int  exp_cnt8, exp_cnt2;
  bit  m_ev, m_inb, m_hit;
  int  m_first, m_lo, m_hi;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int b = 0; b < NB; b++) begin
        m_run[b] = 0; m_miss[b] = 0; m_hold[b] = 0; m_act[b] = 0;
      end
      exp_fire = 0; exp_fb = 0; exp_cnt8 = 0; exp_cnt2 = 0;
    end else begin
      m_ev = 0;
      m_first = -1;
      if (pitch_valid) begin
        for (int b = 0; b < NB; b++) begin
          m_lo  = int'(band_lo[b*PW +: PW]);
          m_hi  = int'(band_hi[b*PW +: PW]);
          m_inb = (int'(pitch_data) >= m_lo) && (int'(pitch_data) <= m_hi);
          if (m_hold[b] > 0) begin
            m_hold[b]--;
          end else if (m_act[b]) begin
            m_hit = m_inb && (pitch_mag >= thresh_off);
            if (m_hit) m_miss[b] = 0;
            else begin
              m_miss[b]++;
              if (m_miss[b] == OFF) begin
                m_act[b] = 0; m_miss[b] = 0; m_hold[b] = HOLD;
              end
            end
          end else begin
            m_hit = m_inb && (pitch_mag >= thresh_on);
            if (m_hit) begin
              m_run[b]++;
              if (m_run[b] == ON) begin
                m_act[b] = 1; m_run[b] = 0; m_ev = 1;
                if (m_first < 0) m_first = b;
              end
            end else m_run[b] = 0;
          end
        end
      end
      if (clear_count) begin
        exp_cnt8 = 0; exp_cnt2 = 0;
      end else if (m_ev) begin
        if (exp_cnt8 < 255) exp_cnt8++;
        if (exp_cnt2 < 3) exp_cnt2++;
      end
      if (pulse_mode) begin
        exp_fire = m_ev;
        if (m_ev) exp_fb = m_first;
      end else begin
        exp_fire = 0; exp_fb = 0;
        for (int b = NB - 1; b >= 0; b--)
          if (m_act[b]) begin exp_fire = 1; exp_fb = b; end
      end
    end
  end

  function automatic logic [NB-1:0] model_active();
    logic [NB-1:0] v;
    for (int b = 0; b < NB; b++) v[b] = m_act[b];
    return v;
  endfunction

  always @(negedge clk) begin
    check("m_active", 64'(active), 64'(model_active()));
    check("m_fire", 64'(fire), 64'(exp_fire));
    check("m_fire_band", 64'(fire_band), 64'(exp_fb));
    check("m_count", 64'(event_count), 64'(exp_cnt8));
    check("m_count_sat", 64'(event_count_s), 64'(exp_cnt2));
  end

  task automatic frame(input int p, input logic [MW-1:0] m);
    pitch_data  = PW'(p);
    pitch_mag   = m;
    pitch_valid = 1'b1;
    @(negedge clk);
    pitch_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  localparam logic [MW-1:0] HI  = 33'h20000000;
  localparam logic [MW-1:0] MID = 33'h0C000000;
  localparam logic [MW-1:0] LO  = 33'h04000000;

  // Two misses release the band, eight more frames cover the holdoff.
  task automatic release_all();
    for (int i = 0; i < OFF + HOLD; i++) frame(100, HI);
  endtask

  initial begin
    reset_n = 1'b0;
    pitch_data = '0; pitch_mag = '0; pitch_valid = 1'b0;
    band_lo = {PW'(1023), PW'(1023), PW'(1023), PW'(40)};
    band_hi = {PW'(0), PW'(0), PW'(0), PW'(60)};
    thresh_on = 33'h10000000; thresh_off = 33'h08000000;
    pulse_mode = 1'b1; clear_count = 1'b0;
    idle(3);
    check("rst_active", 64'(active), 64'd0);
    check("rst_fire", 64'(fire), 64'd0);
    check("rst_count", 64'(event_count), 64'd0);
    reset_n = 1'b1;
    idle(2);

    // Basic arm: fire pulse after the third hit frame.
    frame(50, HI); frame(50, HI);
    check("arm_nofire", 64'(fire), 64'd0);
    frame(50, HI);
    check("arm_fire", 64'(fire), 64'd1);
    check("arm_band", 64'(fire_band), 64'd0);
    check("arm_active", 64'(active), 64'b0001);
    check("arm_count", 64'(event_count), 64'd1);
    idle(1);
    check("arm_pulse_end", 64'(fire), 64'd0);

    // Hysteresis, release and holdoff.
    frame(50, MID);
    check("hyst_hold", 64'(active), 64'b0001);
    frame(50, LO);
    check("rel_first", 64'(active), 64'b0001);
    frame(50, LO);
    check("rel_done", 64'(active), 64'b0000);
    for (int i = 0; i < HOLD; i++) begin
      frame(50, HI);
      check("holdoff_quiet", 64'({active, fire}), 64'd0);
    end
    frame(50, HI); frame(50, HI);
    check("post_hold_nofire", 64'(fire), 64'd0);
    frame(50, HI);
    check("post_hold_fire", 64'(fire), 64'd1);
    check("post_hold_count", 64'(event_count), 64'd2);
    release_all();

    // An interrupted run restarts the debounce.
    frame(50, HI); frame(50, HI); frame(100, HI);
    frame(50, HI); frame(50, HI);
    check("debounce_nofire", 64'(fire), 64'd0);
    frame(50, HI);
    check("debounce_fire", 64'(fire), 64'd1);
    check("debounce_count", 64'(event_count), 64'd3);
    release_all();

    // Two overlapping bands: one pulse, one count, then level mode.
    band_lo[PW +: PW] = PW'(45); band_hi[PW +: PW] = PW'(55);
    frame(50, HI); frame(50, HI); frame(50, HI);
    check("two_active", 64'(active), 64'b0011);
    check("two_fire", 64'(fire), 64'd1);
    check("two_band", 64'(fire_band), 64'd0);
    check("two_count", 64'(event_count), 64'd4);
    check("two_count_sat", 64'(event_count_s), 64'd3);
    pulse_mode = 1'b0;
    idle(1);
    check("level_fire", 64'(fire), 64'd1);
    frame(42, HI); frame(42, HI);
    check("level_one_band", 64'(active), 64'b0001);
    check("level_fire_held", 64'(fire), 64'd1);
    frame(100, HI); frame(100, HI);
    check("level_off", 64'(fire), 64'd0);
    for (int i = 0; i < HOLD; i++) frame(100, HI);
    pulse_mode = 1'b1;
    idle(1);

    // Saturation of the 2-bit counter and clear priority.
    clear_count = 1'b1; idle(1); clear_count = 1'b0;
    check("clear_idle", 64'(event_count), 64'd0);
    for (int k = 1; k <= 5; k++) begin
      frame(50, HI); frame(50, HI); frame(50, HI);
      check("sat_fire", 64'(fire), 64'd1);
      check("sat_count8", 64'(event_count), 64'(k));
      check("sat_count2", 64'(event_count_s), 64'((k < 3) ? k : 3));
      release_all();
    end
    frame(50, HI); frame(50, HI);
    clear_count = 1'b1;
    frame(50, HI);
    clear_count = 1'b0;
    check("clear_ev_fire", 64'(fire), 64'd1);
    check("clear_ev_count", 64'(event_count), 64'd0);
    check("clear_ev_count2", 64'(event_count_s), 64'd0);

    // Asynchronous reset while active.
    idle(1);
    #3 reset_n = 1'b0;
    #1;
    check("areset_active", 64'(active), 64'd0);
    check("areset_fire", 64'(fire), 64'd0);
    check("areset_band", 64'(fire_band), 64'd0);
    check("areset_count", 64'(event_count), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    frame(50, HI); frame(50, HI);
    check("rearm_nofire", 64'(fire), 64'd0);
    frame(50, HI);
    check("rearm_fire", 64'(fire), 64'd1);
    check("rearm_count", 64'(event_count), 64'd1);
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
